data_sram_responder: RTL and testbench

//  Responder (memory side) of the single-port SRAM-style data bus driven by the CPU top's MEM stage.

---
 rtl/data_sram_responder.sv | 119 +++++++++++
 tb/tb_data_sram_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: single-port SRAM data-bus responder with byte-masked writes and a fixed read latency.
// Optional memory-mapped free-running timer, enabled by defining SRAM_RESP_TIMER_EN.
module data_sram_responder #(
  parameter int          AW         = 10,
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int          LATENCY    = 1,
  parameter string       INIT_FILE  = "",
  parameter logic [31:0] TIMER_ADDR = 32'hBFAF_E000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        rvalid,
  output logic        addr_err
);

  typedef struct packed {
    logic        valid;
    logic        is_read;
    logic        err;
    logic [31:0] data;
  } stage_t;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("data_sram_responder: LATENCY must be in 1..4");
  end

`ifdef SRAM_RESP_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic [31:0]   mem [2**AW];
  logic          in_win;
  logic [AW-1:0] index;
  logic          is_rd;
  logic          timer_hit;
  logic          wr_go;
  logic [31:0]   timer_q;
  logic [31:0]   hold_q;
  stage_t        s0_d;
  stage_t        pipe [LATENCY];
  logic          unused_addr_lsb;

  assign in_win          = (sram_addr[31:AW+2] == BASE[31:AW+2]);
  assign index           = sram_addr[AW+1:2];
  assign is_rd           = (sram_wen == 4'h0);
  assign timer_hit       = TIMER_EN && (sram_addr[31:2] == TIMER_ADDR[31:2]);
  assign wr_go           = sram_en && !is_rd && in_win && !timer_hit;
  assign unused_addr_lsb = ^sram_addr[1:0];

  // NOTE: the array has no reset; its contents survive reset, and a reset-free block maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (!reset && wr_go) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) mem[index][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end
  end

`ifdef SRAM_RESP_TIMER_EN
  // Full-word writes load the counter; partial writes are silently ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (sram_en && timer_hit && sram_wen == 4'hF) begin
      timer_q <= sram_wdata;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end
`else
  assign timer_q = '0;
`endif

  // Entry into the pipe: reads and out-of-window accesses only; in-window writes leave no trace.
  always_comb begin
    // NOTE: default every field first so no path through the branches leaves a latch behind.
    s0_d = '0;
    if (sram_en) begin
      if (timer_hit) begin
        s0_d.valid   = is_rd;
        s0_d.is_read = is_rd;
        s0_d.data    = timer_q;
      end else if (!in_win) begin
        s0_d.valid   = 1'b1;
        s0_d.is_read = is_rd;
        s0_d.err     = 1'b1;
      end else if (is_rd) begin
        s0_d.valid   = 1'b1;
        s0_d.is_read = 1'b1;
        s0_d.data    = mem[index];
      end
    end
  end

  // NOTE: state registers use <= so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      hold_q <= '0;
    end else begin
      pipe[0] <= s0_d;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      if (pipe[LATENCY-1].valid && pipe[LATENCY-1].is_read) hold_q <= pipe[LATENCY-1].data;
    end
  end

  // Read data stays on the bus after the rvalid pulse until the next read completes.
  assign rvalid     = pipe[LATENCY-1].valid & pipe[LATENCY-1].is_read;
  assign addr_err   = pipe[LATENCY-1].valid & pipe[LATENCY-1].err;
  assign sram_rdata = rvalid ? pipe[LATENCY-1].data : hold_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: a LATENCY=1 and a LATENCY=3 instance share one stimulus stream
// and are compared against a transaction-level model (word array plus per-edge response history).
`timescale 1ns/1ps
module tb_data_sram_responder;

  localparam logic [31:0] TADDR = 32'hBFAF_E000;

  typedef struct packed {
    logic        valid;
    logic        rd;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata3;
  logic        rvalid1, rvalid3, err1, err3;

  int tests = 0;
  int fails = 0;

  // Model state
  resp_t       hist [0:4095];
  int          n = 0;
  logic [31:0] mref [int];
  logic [31:0] cnt_m;
  logic [31:0] held [2];
  logic        exp_rvalid [2];
  logic        exp_err [2];
  logic [31:0] exp_rdata [2];

  always #5 clk = ~clk;

  data_sram_responder #(.LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .sram_en(en), .sram_wen(wen), .sram_addr(addr),
    .sram_wdata(wdata), .sram_rdata(rdata1), .rvalid(rvalid1), .addr_err(err1)
  );

  data_sram_responder #(.LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset), .sram_en(en), .sram_wen(wen), .sram_addr(addr),
    .sram_wdata(wdata), .sram_rdata(rdata3), .rvalid(rvalid3), .addr_err(err3)
  );

  // Drive one request, advance one clock, then compute what each latency should show in the following cycle.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    resp_t       r;
    bit          inw;
    bit          tmr;
    int          idx;
    logic [31:0] word;
    en = e; wen = w; addr = a; wdata = d;
    inw = (a[31:12] == 20'h0);
    idx = int'(a[11:2]);
`ifdef SRAM_RESP_TIMER_EN
    tmr = (a[31:2] == TADDR[31:2]);
`else
    tmr = 1'b0;
`endif
    r = '0;
    if (e) begin
      if (tmr) begin
        if (w == 4'h0) begin
          r.valid = 1'b1; r.rd = 1'b1; r.data = cnt_m;
        end
      end else if (!inw) begin
        r.valid = 1'b1; r.rd = (w == 4'h0); r.err = 1'b1;
      end else if (w == 4'h0) begin
        r.valid = 1'b1; r.rd = 1'b1;
        r.data = mref.exists(idx) ? mref[idx] : 32'hx;
      end else begin
        word = mref.exists(idx) ? mref[idx] : 32'hx;
        for (int b = 0; b < 4; b++) if (w[b]) word[8*b +: 8] = d[8*b +: 8];
        mref[idx] = word;
      end
    end
    if (e && tmr && w == 4'hF) cnt_m = d;
    else cnt_m = cnt_m + 32'd1;
    n++;
    hist[n] = r;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int    j;
      resp_t h;
      j = n - ((k == 0) ? 1 : 3) + 1;
      h = (j >= 1) ? hist[j] : resp_t'(0);
      exp_rvalid[k] = h.valid && h.rd;
      exp_err[k]    = h.valid && h.err;
      if (exp_rvalid[k]) held[k] = h.data;
      exp_rdata[k] = held[k];
    end
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Assert reset at the current (negedge) point; the caller releases it. In-flight responses vanish.
  task automatic assert_reset();
    reset = 1'b1;
    en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    for (int i = 0; i < 4; i++) if (n - i >= 0) hist[n-i] = '0;
    held[0] = '0; held[1] = '0;
    cnt_m = '0;
    #1;
  endtask

  task automatic test_reset();
    assert_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (rvalid1 !== 1'b0 || rvalid3 !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b/%b want 0/0", rvalid1, rvalid3); end
    tests++; if (err1 !== 1'b0 || err3 !== 1'b0) begin fails++; $display("FAIL reset_addr_err: got %b/%b want 0/0", err1, err3); end
    tests++; if (rdata1 !== 32'h0 || rdata3 !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h/%h want 0/0", rdata1, rdata3); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    step(1'b1, 4'hF, 32'h10, 32'h1122_3344);
    step(1'b1, 4'h0, 32'h10, 32'h0);
    tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h1122_3344) begin fails++; $display("FAIL wr_rd_lat1: got v=%b d=%h want v=1 d=11223344", rvalid1, rdata1); end
    tests++; if (rvalid3 !== 1'b0) begin fails++; $display("FAIL wr_rd_lat3_early: got v=%b want 0", rvalid3); end
    idle();
    tests++; if (rvalid1 !== 1'b0 || rdata1 !== 32'h1122_3344) begin fails++; $display("FAIL rdata_hold: got v=%b d=%h want v=0 d=11223344", rvalid1, rdata1); end
    idle();
    tests++; if (rvalid3 !== 1'b1 || rdata3 !== 32'h1122_3344) begin fails++; $display("FAIL wr_rd_lat3: got v=%b d=%h want v=1 d=11223344", rvalid3, rdata3); end
  endtask

  task automatic test_byte_mask();
    step(1'b1, 4'hF, 32'h20, 32'hAABB_CCDD);
    step(1'b1, 4'b0101, 32'h20, 32'h1122_3344);
    step(1'b1, 4'h0, 32'h20, 32'h0);
    tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hAA22_CC44) begin fails++; $display("FAIL byte_mask: got v=%b d=%h want v=1 d=aa22cc44", rvalid1, rdata1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want3 [6];
    logic        wantv3 [6];
    want3  = '{32'hAA22_CC44, 32'hAA22_CC44, 32'd1, 32'd2, 32'd3, 32'd3};
    wantv3 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    step(1'b1, 4'hF, 32'h0, 32'd1);
    step(1'b1, 4'hF, 32'h4, 32'd2);
    step(1'b1, 4'hF, 32'h8, 32'd3);
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(1'b1, 4'h0, 32'(4 * i), 32'h0);
      else idle();
      if (i < 3) begin
        tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'(i + 1)) begin fails++; $display("FAIL b2b_lat1[%0d]: got v=%b d=%h want v=1 d=%h", i, rvalid1, rdata1, i + 1); end
      end
      tests++; if (rvalid3 !== wantv3[i] || rdata3 !== want3[i]) begin fails++; $display("FAIL b2b_lat3[%0d]: got v=%b d=%h want v=%b d=%h", i, rvalid3, rdata3, wantv3[i], want3[i]); end
    end
  endtask

  task automatic test_out_of_window();
    step(1'b1, 4'h0, 32'h0000_1000, 32'h0);
    tests++; if (rvalid1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'h0) begin fails++; $display("FAIL oow_read: got v=%b e=%b d=%h want 1 1 0", rvalid1, err1, rdata1); end
    step(1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
    tests++; if (rvalid1 !== 1'b0 || err1 !== 1'b1) begin fails++; $display("FAIL oow_write: got v=%b e=%b want v=0 e=1", rvalid1, err1); end
    idle();
    tests++; if (err1 !== 1'b0 || rvalid3 !== 1'b1 || err3 !== 1'b1 || rdata3 !== 32'h0) begin fails++; $display("FAIL oow_read_lat3: got e1=%b v=%b e=%b d=%h want 0 1 1 0", err1, rvalid3, err3, rdata3); end
    step(1'b1, 4'h0, 32'h0, 32'h0);
    tests++; if (rvalid3 !== 1'b0 || err3 !== 1'b1) begin fails++; $display("FAIL oow_write_lat3: got v=%b e=%b want v=0 e=1", rvalid3, err3); end
    tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'd1) begin fails++; $display("FAIL oow_mem_untouched: got v=%b d=%h want v=1 d=1", rvalid1, rdata1); end
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 4'h0, 32'h20, 32'h0);
    assert_reset();
    tests++; if (rvalid1 !== 1'b0 || rvalid3 !== 1'b0 || rdata1 !== 32'h0 || rdata3 !== 32'h0) begin fails++; $display("FAIL inflight_reset: got v=%b/%b d=%h/%h want 0/0 0/0", rvalid1, rvalid3, rdata1, rdata3); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (rvalid3 !== 1'b0 || rdata3 !== 32'h0) begin fails++; $display("FAIL inflight_held: got v=%b d=%h want v=0 d=0", rvalid3, rdata3); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      tests++; if (rvalid3 !== 1'b0 || rvalid1 !== 1'b0) begin fails++; $display("FAIL inflight_dropped[%0d]: got v=%b/%b want 0/0", i, rvalid1, rvalid3); end
    end
    step(1'b1, 4'h0, 32'h20, 32'h0);
    tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hAA22_CC44) begin fails++; $display("FAIL mem_survives_reset: got v=%b d=%h want v=1 d=aa22cc44", rvalid1, rdata1); end
  endtask

  task automatic test_timer();
`ifdef SRAM_RESP_TIMER_EN
    step(1'b1, 4'hF, TADDR, 32'h0000_0100);
    repeat (5) idle();
    step(1'b1, 4'h0, TADDR, 32'h0);
    tests++; if (rvalid1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== 32'h0000_0105) begin fails++; $display("FAIL timer_read: got v=%b e=%b d=%h want 1 0 00000105", rvalid1, err1, rdata1); end
    step(1'b1, 4'h3, TADDR, 32'hFFFF_FFFF);
    tests++; if (err1 !== 1'b0 || rvalid1 !== 1'b0) begin fails++; $display("FAIL timer_partial: got v=%b e=%b want 0 0", rvalid1, err1); end
    step(1'b1, 4'h0, TADDR, 32'h0);
    tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h0000_0107) begin fails++; $display("FAIL timer_after_partial: got v=%b d=%h want v=1 d=00000107", rvalid1, rdata1); end
`else
    step(1'b1, 4'h0, TADDR, 32'h0);
    tests++; if (rvalid1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'h0) begin fails++; $display("FAIL timer_addr_decode: got v=%b e=%b d=%h want 1 1 0", rvalid1, err1, rdata1); end
`endif
  endtask

  task automatic test_random();
    logic        e;
    logic [3:0]  w;
    logic [31:0] a;
    for (int i = 0; i < 32; i++) step(1'b1, 4'hF, 32'(4 * i), $urandom);
    for (int s = 0; s < 400; s++) begin
      e = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        a[12] = 1'b1;
        if (a[31:2] == TADDR[31:2]) a[13] = ~a[13];
      end else begin
        a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      end
      step(e, w, a, $urandom);
      for (int k = 0; k < 2; k++) begin
        logic        av;
        logic        ae;
        logic [31:0] ad;
        av = (k == 0) ? rvalid1 : rvalid3;
        ae = (k == 0) ? err1 : err3;
        ad = (k == 0) ? rdata1 : rdata3;
        tests++; if (av !== exp_rvalid[k]) begin fails++; $display("FAIL rand_rvalid inst%0d step%0d: got %b want %b", k, s, av, exp_rvalid[k]); end
        tests++; if (ae !== exp_err[k]) begin fails++; $display("FAIL rand_addr_err inst%0d step%0d: got %b want %b", k, s, ae, exp_err[k]); end
        tests++; if (ad !== exp_rdata[k]) begin fails++; $display("FAIL rand_rdata inst%0d step%0d: got %h want %h", k, s, ad, exp_rdata[k]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    cnt_m = '0;
    held[0] = '0; held[1] = '0;
    for (int i = 0; i < 4096; i++) hist[i] = '0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_out_of_window();
    test_reset_inflight();
    test_timer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
